// File: rtl/collector.sv
// rtl/collector.sv - de-skews four staggered lane streams into a registered 4x4 matrix
// Wavefront wf lands on the anti-diagonal r+c == wf (0-based row/column).
module collector #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] q1,
  input  logic [DW-1:0] q2,
  input  logic [DW-1:0] q3,
  input  logic [DW-1:0] q4,
  output logic [DW-1:0] o11,
  output logic [DW-1:0] o12,
  output logic [DW-1:0] o13,
  output logic [DW-1:0] o14,
  output logic [DW-1:0] o21,
  output logic [DW-1:0] o22,
  output logic [DW-1:0] o23,
  output logic [DW-1:0] o24,
  output logic [DW-1:0] o31,
  output logic [DW-1:0] o32,
  output logic [DW-1:0] o33,
  output logic [DW-1:0] o34,
  output logic [DW-1:0] o41,
  output logic [DW-1:0] o42,
  output logic [DW-1:0] o43,
  output logic [DW-1:0] o44,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]    state;
  logic [2:0]    wf;
  logic [DW-1:0] m [4][4];
  logic [DW-1:0] lane [4];

  assign lane[0] = q1;
  assign lane[1] = q2;
  assign lane[2] = q3;
  assign lane[3] = q4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wf    <= 3'd0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          m[r][c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CAPTURE;
            wf    <= 3'd0;
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                m[r][c] <= '0;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            // Lanes outside the current anti-diagonal carry filler and are dropped.
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                if (int'(wf) == r + c)
                  m[r][c] <= lane[r];
            if (wf == 3'd6) begin
              state <= S_DONE;
              wf    <= 3'd0;
            end else begin
              wf <= wf + 3'd1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_CAPTURE;
            wf    <= 3'd0;
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                m[r][c] <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CAPTURE);
  assign done = (state == S_DONE);

  assign o11 = m[0][0];
  assign o12 = m[0][1];
  assign o13 = m[0][2];
  assign o14 = m[0][3];
  assign o21 = m[1][0];
  assign o22 = m[1][1];
  assign o23 = m[1][2];
  assign o24 = m[1][3];
  assign o31 = m[2][0];
  assign o32 = m[2][1];
  assign o33 = m[2][2];
  assign o34 = m[2][3];
  assign o41 = m[3][0];
  assign o42 = m[3][1];
  assign o43 = m[3][2];
  assign o44 = m[3][3];

endmodule

// File: tb/tb_collector.sv
// tb/tb_collector.sv - directed self-checking bench for collector
module tb_collector;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] q1 = '0, q2 = '0, q3 = '0, q4 = '0;
  logic [DW-1:0] o11, o12, o13, o14, o21, o22, o23, o24;
  logic [DW-1:0] o31, o32, o33, o34, o41, o42, o43, o44;
  logic          busy, done;
  logic [DW-1:0] obs [4][4];
  int            checks = 0;
  int            errors = 0;

  collector #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .o11(o11), .o12(o12), .o13(o13), .o14(o14),
    .o21(o21), .o22(o22), .o23(o23), .o24(o24),
    .o31(o31), .o32(o32), .o33(o33), .o34(o34),
    .o41(o41), .o42(o42), .o43(o43), .o44(o44),
    .busy(busy), .done(done)
  );

  assign obs[0][0] = o11; assign obs[0][1] = o12; assign obs[0][2] = o13; assign obs[0][3] = o14;
  assign obs[1][0] = o21; assign obs[1][1] = o22; assign obs[1][2] = o23; assign obs[1][3] = o24;
  assign obs[2][0] = o31; assign obs[2][1] = o32; assign obs[2][2] = o33; assign obs[2][3] = o34;
  assign obs[3][0] = o41; assign obs[3][1] = o42; assign obs[3][2] = o43; assign obs[3][3] = o44;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected element once the first n wavefronts have been captured.
  function automatic logic [DW-1:0] expv(int r, int c, int n, bit ident, logic [DW-1:0] off);
    if (r + c >= n) return '0;
    if (ident) return (r == c) ? 32'h0000ffff : 32'h0;
    return off + 32'(256 * (r + 1) + (c + 1));
  endfunction

  // Skewed stimulus: lane r at wavefront k carries row r, column k-r.
  task automatic drive_wave(input int k, input bit ident, input logic [DW-1:0] off);
    logic [DW-1:0] v [4];
    for (int r = 0; r < 4; r++) begin
      if (k - r >= 0 && k - r <= 3)
        v[r] = ident ? ((r == k - r) ? 32'h0000ffff : 32'h0) : off + 32'(256 * (r + 1) + (k - r + 1));
      else
        v[r] = ident ? 32'h0 : 32'hdeadbeef;
    end
    q1 = v[0]; q2 = v[1]; q3 = v[2]; q4 = v[3];
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    int bad;
    #2;
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (obs[r][c] !== '0) bad++;
    checks++;
    if (bad != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: nonzero=%0d busy=%b done=%b required 0/0/0", bad, busy, done);
    end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_identity;
    int bad;
    int busy_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    busy_cnt = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL identity_entry: busy=%b done=%b required 1/0", busy, done);
    end
    if (busy === 1'b1) busy_cnt++;
    for (int k = 0; k < 7; k++) begin
      drive_wave(k, 1'b1, '0);
      tick;
      if (busy === 1'b1) busy_cnt++;
      if (k < 6) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL identity_early_done k=%0d: done=%b required 0", k, done);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL identity_done_edge8: done=%b busy=%b required 1/0", done, busy);
    end
    checks++;
    if (busy_cnt != 7) begin
      errors++;
      $display("FAIL identity_busy_cycles: got %0d required 7", busy_cnt);
    end
    tick;
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (obs[r][c] !== expv(r, c, 7, 1'b1, '0)) bad++;
    checks++;
    if (bad != 0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL identity_matrix: wrong=%0d done=%b busy=%b required 0/0/0 o11=%h o22=%h", bad, done, busy, o11, o22);
    end
  endtask

  task automatic test_full;
    int bad;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive_wave(k, 1'b0, '0);
      tick;
      bad = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (obs[r][c] !== expv(r, c, k + 1, 1'b0, '0)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL full_wave%0d: wrong elements=%0d required 0 (o14=%h o41=%h)", k, bad, o14, o41);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL full_done: done=%b required 1", done);
    end
    tick;
  endtask

  task automatic test_stall;
    // 1 = capture next wavefront, 0 = stall cycle
    bit seq [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1};
    int k;
    int edges;
    int done_edge;
    int bad;
    k = 0;
    done_edge = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    edges = 1;
    for (int i = 0; i < 11; i++) begin
      if (seq[i]) drive_wave(k, 1'b0, 32'h30000);
      else begin
        in_valid = 1'b0;
        q1 = 32'hdeadbeef; q2 = 32'hdeadbeef; q3 = 32'hdeadbeef; q4 = 32'hdeadbeef;
      end
      tick;
      edges++;
      if (seq[i]) k++;
      if (done === 1'b1 && done_edge < 0) done_edge = edges;
      bad = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (obs[r][c] !== expv(r, c, k, 1'b0, 32'h30000)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL stall_step%0d: wrong elements=%0d required 0", i, bad);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done_edge != 12) begin
      errors++;
      $display("FAIL stall_done_edge: got %0d required 12", done_edge);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int bad;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive_wave(k, 1'b0, 32'h40000);
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b required 1", done);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (obs[r][c] !== '0) bad++;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || bad != 0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b nonzero=%0d required 1/0/0", busy, done, bad);
    end
    for (int k = 0; k < 7; k++) begin
      drive_wave(k, 1'b0, 32'h50000);
      tick;
    end
    in_valid = 1'b0;
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (obs[r][c] !== expv(r, c, 7, 1'b0, 32'h50000)) bad++;
    checks++;
    if (done !== 1'b1 || bad != 0) begin
      errors++;
      $display("FAIL b2b_second: done=%b wrong=%0d required 1/0 o44=%h", done, bad, o44);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int bad;
    int seen_bad;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_wave(k, 1'b0, 32'h60000);
      tick;
    end
    drive_wave(3, 1'b0, 32'h60000);
    #2 rst_n = 1'b0;
    #1;
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (obs[r][c] !== '0) bad++;
    checks++;
    if (bad != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: nonzero=%0d busy=%b done=%b required 0/0/0", bad, busy, done);
    end
    #1 rst_n = 1'b1;
    seen_bad = 0;
    for (int k = 3; k < 7; k++) begin
      drive_wave(k, 1'b0, 32'h60000);
      tick;
      if (busy !== 1'b0 || done !== 1'b0 || o11 !== '0) seen_bad++;
    end
    checks++;
    if (seen_bad != 0) begin
      errors++;
      $display("FAIL reset_mid_idle: bad cycles=%0d required 0", seen_bad);
    end
    in_valid = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive_wave(k, 1'b0, 32'h70000);
      tick;
    end
    in_valid = 1'b0;
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (obs[r][c] !== expv(r, c, 7, 1'b0, 32'h70000)) bad++;
    checks++;
    if (done !== 1'b1 || bad != 0) begin
      errors++;
      $display("FAIL reset_mid_recapture: done=%b wrong=%0d required 1/0", done, bad);
    end
    tick;
  endtask

  task automatic test_start_ignored;
    int bad;
    int early;
    start = 1'b1;
    tick;
    start = 1'b0;
    early = 0;
    for (int k = 0; k < 7; k++) begin
      drive_wave(k, 1'b0, 32'h80000);
      start = (k == 4);
      tick;
      start = 1'b0;
      if (k < 6 && (done !== 1'b0 || busy !== 1'b1)) early++;
    end
    in_valid = 1'b0;
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (obs[r][c] !== expv(r, c, 7, 1'b0, 32'h80000)) bad++;
    checks++;
    if (done !== 1'b1 || bad != 0 || early != 0) begin
      errors++;
      $display("FAIL start_ignored: done=%b wrong=%0d early=%0d required 1/0/0", done, bad, early);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_idle: busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_full;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_start_ignored;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
